// File: rtl/cray_uart_pkg.sv
// Shared register offsets, status bit positions and FSM encodings for the
// memory-mapped console UART.
package cray_uart_pkg;

  localparam logic [1:0] TXBUSY = 2'd0;
  localparam logic [1:0] RXSTAT = 2'd1;
  localparam logic [1:0] RXDATA = 2'd2;
  localparam logic [1:0] TXDATA = 2'd3;

  localparam int STAT_READY     = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT_CTS,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/cray_uart_rx_frame.sv
// Serial receive front end: synchronizes UART_RX, finds start bits and
// samples 8N1 frames at mid-bit, reporting a good byte or a framing error.
module cray_uart_rx_frame
  import cray_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Going back to idle at the stop-bit midpoint leaves half a bit of slack
  // to catch the next start edge of a back-to-back frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cray_uart_mmio.sv
// CPU-facing UART responder: register file, bus handshake and the CTS-gated
// 8N1 transmitter; frame reception is delegated to cray_uart_rx_frame.
module cray_uart_mmio
  import cray_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_WIDTH   = 64
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  SEL,
  input  logic                  WE,
  input  logic [1:0]            ADDR,
  input  logic [WORD_WIDTH-1:0] WDATA,
  output logic [WORD_WIDTH-1:0] RDATA,
  output logic                  ACK,
  input  logic                  UART_RX,
  output logic                  UART_TX,
  input  logic                  UART_CTS,
  output logic                  UART_RTS
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t             tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [2:0]            tx_bit_idx;
  logic [7:0]            tx_shreg;
  logic                  tx_busy;
  logic                  rx_ready;
  logic                  overrun;
  logic                  frame_err;
  logic [7:0]            rx_data;
  logic                  rx_byte_valid;
  logic [7:0]            rx_byte;
  logic                  rx_frame_err;
  logic                  wr_tx;
  logic                  wr_clr;
  logic [WORD_WIDTH-1:0] read_val;
  logic                  unused_wdata;

  assign unused_wdata = ^WDATA[WORD_WIDTH-1:8];
  assign wr_tx        = SEL && WE && (ADDR == TXDATA) && !tx_busy;
  assign wr_clr       = SEL && WE && (ADDR == RXDATA);
  assign UART_RTS     = rx_ready;

  cray_uart_rx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_frame (
    .clock     (CLOCK),
    .reset     (RESET),
    .rx        (UART_RX),
    .byte_valid(rx_byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_frame_err)
  );

  always_comb begin
    read_val = '0;
    case (ADDR)
      TXBUSY: read_val[0] = tx_busy;
      RXSTAT: begin
        read_val[STAT_READY]     = rx_ready;
        read_val[STAT_OVERRUN]   = overrun;
        read_val[STAT_FRAME_ERR] = frame_err;
      end
      RXDATA:  read_val[7:0] = rx_data;
      default: read_val = '0;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ACK   <= 1'b0;
      RDATA <= '0;
    end else begin
      ACK   <= SEL;
      RDATA <= (SEL && !WE) ? read_val : '0;
    end
  end

  // A completing frame overrides a same-cycle clear; overrun only counts
  // against a byte that was still pending and not being cleared.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (wr_clr) begin
        rx_ready  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_byte_valid) begin
        rx_ready <= 1'b1;
        rx_data  <= rx_byte;
        overrun  <= wr_clr ? 1'b0 : (overrun | rx_ready);
      end
      if (rx_frame_err) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tx_state   <= TX_IDLE;
      UART_TX    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx_shreg   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt     <= '0;
          tx_bit_idx <= '0;
          if (wr_tx) begin
            tx_busy  <= 1'b1;
            tx_shreg <= WDATA[7:0];
            if (!UART_CTS) begin
              tx_state <= TX_START;
              UART_TX  <= 1'b0;
            end else begin
              tx_state <= TX_WAIT_CTS;
            end
          end
        end
        TX_WAIT_CTS: begin
          if (!UART_CTS) begin
            tx_state <= TX_START;
            UART_TX  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
            UART_TX  <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit_idx == 3'd7) begin
              tx_state <= TX_STOP;
              UART_TX  <= 1'b1;
            end else begin
              tx_bit_idx <= tx_bit_idx + 1'b1;
              UART_TX    <= tx_shreg[0];
              tx_shreg   <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
